// File: rtl/soc_arb_pkg.sv
// Shared types for the two-port core data arbiter.
package soc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Source port identifier: 0 = core data port, 1 = instruction fetch port.
    typedef logic arb_port_t;

    localparam arb_port_t PORT0 = 1'b0;
    localparam arb_port_t PORT1 = 1'b1;

    function automatic arb_port_t other_port(input arb_port_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/arb_route_fifo.sv
// Route FIFO: remembers which port issued each accepted request so
// responses can be steered back in order.
module arb_route_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Flags come from the registered count only, so full never depends on a same-cycle pop.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; a pop on an empty FIFO is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage.
    // NOTE: storage has no reset; only slots covered by count_q are ever read as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/core_data_arb2.sv
// Two-to-one OBI-style data arbiter: core data port and instruction fetch
// port share one downstream port, with a lock while a request is stalled
// and in-order response routing through a small route FIFO.
module core_data_arb2
    import soc_arb_pkg::*;
#(
    parameter int   MAX_OUTSTANDING = 2,
    parameter logic PRIO_P0         = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // port 0: core data
    input  logic        p0_data_req_i,
    output logic        p0_data_gnt_o,
    output logic        p0_data_rvalid_o,
    input  logic [31:0] p0_data_addr_i,
    input  logic        p0_data_we_i,
    input  logic [3:0]  p0_data_be_i,
    input  logic [31:0] p0_data_wdata_i,
    output logic [31:0] p0_data_rdata_o,
    // port 1: instruction fetch
    input  logic        p1_data_req_i,
    output logic        p1_data_gnt_o,
    output logic        p1_data_rvalid_o,
    input  logic [31:0] p1_data_addr_i,
    input  logic        p1_data_we_i,
    input  logic [3:0]  p1_data_be_i,
    input  logic [31:0] p1_data_wdata_i,
    output logic [31:0] p1_data_rdata_o,
    // downstream
    output logic        m_data_req_o,
    input  logic        m_data_gnt_i,
    input  logic        m_data_rvalid_i,
    output logic [31:0] m_data_addr_o,
    output logic        m_data_we_o,
    output logic [3:0]  m_data_be_o,
    output logic [31:0] m_data_wdata_o,
    input  logic [31:0] m_data_rdata_i
);

    localparam arb_port_t RR_RESET = PRIO_P0 ? PORT0 : PORT1;

    arb_state_e state_q, state_d;
    arb_port_t  owner_q, owner_d;
    arb_port_t  rr_q, rr_d;
    arb_port_t  sel;
    logic       sel_req;
    logic       handshake;
    logic       fifo_full;
    logic       fifo_empty;
    arb_port_t  fifo_head;
    logic       rsp_pop;

    // Port selection: a stalled owner keeps the bus, otherwise lone requester or rr_ptr on contention.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel     = PORT0;
        sel_req = 1'b0;
        if (state_q == ARB_LOCKED) begin
            sel = owner_q;
        end else if (p0_data_req_i && p1_data_req_i) begin
            sel = rr_q;
        end else if (p1_data_req_i) begin
            sel = PORT1;
        end
        // Requests are masked during reset so every output is quiet.
        sel_req = rst_ni & ((sel == PORT1) ? p1_data_req_i : p0_data_req_i);
    end

    assign m_data_req_o  = sel_req & ~fifo_full;
    assign handshake     = m_data_req_o & m_data_gnt_i;
    assign p0_data_gnt_o = (sel == PORT0) & m_data_gnt_i & ~fifo_full;
    assign p1_data_gnt_o = (sel == PORT1) & m_data_gnt_i & ~fifo_full;

    // Downstream address/control mux; all zero when nothing is selected.
    always_comb begin
        m_data_addr_o  = '0;
        m_data_we_o    = 1'b0;
        m_data_be_o    = '0;
        m_data_wdata_o = '0;
        if (sel_req) begin
            if (sel == PORT1) begin
                m_data_addr_o  = p1_data_addr_i;
                m_data_we_o    = p1_data_we_i;
                m_data_be_o    = p1_data_be_i;
                m_data_wdata_o = p1_data_wdata_i;
            end else begin
                m_data_addr_o  = p0_data_addr_i;
                m_data_we_o    = p0_data_we_i;
                m_data_be_o    = p0_data_be_i;
                m_data_wdata_o = p0_data_wdata_i;
            end
        end
    end

    // Next-state: lock onto a driven-but-stalled request, release on its grant, rotate priority on contention.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (m_data_req_o && !m_data_gnt_i) begin
                    state_d = ARB_LOCKED;
                    owner_d = sel;
                end
            end
            ARB_LOCKED: begin
                if (handshake) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (handshake && p0_data_req_i && p1_data_req_i) begin
            rr_d = other_port(sel);
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            owner_q <= PORT0;
            rr_q    <= RR_RESET;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (m_data_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Responses go only to the port at the FIFO head; stray responses are dropped.
    assign rsp_pop          = m_data_rvalid_i & ~fifo_empty;
    assign p0_data_rvalid_o = rsp_pop & (fifo_head == PORT0);
    assign p1_data_rvalid_o = rsp_pop & (fifo_head == PORT1);
    assign p0_data_rdata_o  = m_data_rdata_i;
    assign p1_data_rdata_o  = m_data_rdata_i;

endmodule

// File: doc/core_data_arb2.md
CORE_DATA_ARB2 -- requirements
Module: core_data_arb2

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 2, max accepted-but-unanswered transactions (legal 1..8).
REQ-002 Parameter: PRIO_P0, default 1'b1, winner of the first contention after reset (1 = port 0, 0 = port 1).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 p0_inf  CORE_DATA_INF.Slave  bundle  core data port (data_req, data_gnt, data_rvalid, data_addr[31:0], data_we, data_be[3:0], data_wdata[31:0], data_rdata[31:0]).
REQ-006 p1_inf  CORE_DATA_INF.Slave  bundle  instruction fetch port, fed by the inst-to-data converter (we=0, be=0, wdata=0).
REQ-007 m_inf  CORE_DATA_INF.Master  bundle  single downstream port to shared memory/bus.

Function
REQ-008 Protocol on all ports SHALL be OBI-style: transfer accepted in a cycle with req&gnt; exactly one rvalid per accepted transfer, in order, no earlier than the cycle after acceptance.
REQ-009 Arbiter FSM SHALL have states IDLE and LOCKED.
REQ-010 IDLE: if exactly one port requests, that port is selected; if both, the port indicated by rr_ptr is selected.
REQ-011 IDLE -> LOCKED when the selected request is driven to m_inf and not granted that cycle; owner register captures the selected port.
REQ-012 LOCKED: owner SHALL stay selected, m_inf address/controls SHALL come from owner, other port SHALL see gnt=0; LOCKED -> IDLE on the cycle owner is granted.
REQ-013 rr_ptr SHALL toggle to the non-winning port on every contended grant; uncontended grants SHALL NOT change rr_ptr.
REQ-014 m_inf.data_req = selected req AND NOT fifo_full; selected port gnt = m_inf.data_gnt AND NOT fifo_full; unselected port gnt = 0.
REQ-015 m_inf address, we, be, wdata SHALL be combinational muxes of the selected port; with no request, all SHALL be driven 0.
REQ-016 Route FIFO (depth MAX_OUTSTANDING, 1-bit entries = source port) SHALL push on m_inf req&gnt and pop on m_inf.data_rvalid.
REQ-017 fifo_full SHALL be based on registered count only; push while full is impossible (gated by REQ-014); simultaneous push and pop SHALL leave count unchanged.
REQ-018 rvalid SHALL be forwarded only to the port at FIFO head; other port rvalid=0; rdata SHALL be m_inf.data_rdata to both ports.
REQ-019 rvalid with empty FIFO SHALL be dropped (no port sees rvalid) and the count SHALL not underflow.
REQ-020 Read/write pointers SHALL wrap modulo MAX_OUTSTANDING; count width = $clog2(MAX_OUTSTANDING+1).
REQ-021 Zero added latency: grant and response paths are combinational through the block.

Reset
REQ-022 During reset: FSM=IDLE, rr_ptr=PRIO_P0 selection, FIFO pointers and count = 0, owner = 0.
REQ-023 Reset mid-operation SHALL discard in-flight route entries; subsequent rvalid SHALL be dropped per REQ-019.
REQ-024 All outputs SHALL be 0 while rst_ni=0, given downstream gnt/rvalid inputs are 0.

Structure
REQ-025 Package soc_arb_pkg SHALL hold arb_state_e {ARB_IDLE, ARB_LOCKED} and port-id typedef arb_port_t (1 bit).
REQ-026 Route FIFO SHALL be a separate sub-module arb_route_fifo (parameter DEPTH, WIDTH) with push, pop, full, empty, head.

Verification
REQ-027 Both ports req, addr 0x100 (p0) / 0x200 (p1), memory always-gnt, 1-cycle rvalid -> m addr sequence 0x100, 0x200, 0x100...; rdata routed to matching port.
REQ-028 p1 req at 0x80, m gnt held low 3 cycles, p0 req rises in cycle 2 -> m addr stays 0x80 until gnt; p0 gnt=0 throughout; p0 served next.
REQ-029 MAX_OUTSTANDING=2, gnt always 1, rvalid withheld -> 2 grants then m req=0 until first rvalid; third grant on rvalid cycle+0 not allowed, next cycle allowed.
REQ-030 Interleaved p0 write (be=0xF, wdata=0xDEADBEEF) and p1 read with 2-cycle rvalid latency -> rvalid order p0 then p1, no cross-delivery.
REQ-031 rst_ni pulsed low with 2 outstanding, then spurious rvalid -> both port rvalid=0, count stays 0.
REQ-032 Spurious rvalid with empty FIFO out of reset -> dropped, no port rvalid.
